pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline stage register, the general replacement for the fixed per-stage registers between CPU pipeline stages (IF/ID … MEM/WB). It carries a data payload, the 32-bit instruction word and a control bundle, with valid/ready flow control, flush, and bubble masking so an empty stage never asserts control. It also provides a saturating back-pressure counter. An optional skid buffer registers `in_ready` for timing closure.

## Interface
- `DATA_W`, 32: payload width (e.g. rd/ALU result).
- `CTRL_W`, 1: control bundle width (e.g. regWEn, memRW, …).
- `CNT_W`, 16: stall counter width.
- `NOP_INST`, 32'h0000_0013: instruction word presented when the stage holds a bubble (`addi x0,x0,0`).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held and incoming entries.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage accepts an entry this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `in_inst`  in  32  upstream instruction word.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `out_valid`  out  1  stage holds a valid entry.
- `out_ready`  in  1  downstream consumes the entry this cycle.
- `out_data`  out  DATA_W  held payload.
- `out_inst`  out  32  held instruction, or `NOP_INST` when `out_valid`=0.
- `out_ctrl`  out  CTRL_W  held control, forced to 0 when `out_valid`=0.
- `stall_cnt`  out  CNT_W  cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Accept: an entry is accepted on an edge where `in_valid && in_ready && flush`=0. Transfer out: on an edge where `out_valid && out_ready`.
- Priority per edge: `reset`=0 > `flush`=1 > normal handshake.
- Reset (`reset`=0 at an edge): all valids 0, `out_data`=0, internal inst/ctrl registers = 0, `stall_cnt`=0. Outputs after reset: `out_valid`=0, `out_inst`=`NOP_INST`, `out_ctrl`=0, `out_data`=0, `in_ready`=1 (skid) / 1 (no skid). Reset during an active stall or a full skid discards all entries.
- Flush: clears every valid bit at the edge. The incoming beat is dropped. `in_ready` is driven 0 while `flush`=1. `out_data` keeps its last value. `stall_cnt` is not cleared.
- Bubble masking (combinational on outputs): `out_ctrl = out_valid ? ctrl_q : 0`, `out_inst = out_valid ? inst_q : NOP_INST`. `out_data` is not masked.
- Payload is never modified. Ordering is strictly FIFO; no entry is duplicated or lost except through flush or reset.
- `stall_cnt` increments by 1 on each edge where `out_valid && !out_ready`, saturates at 2^CNT_W−1, and is cleared only by reset.

## Timing
- Latency: an entry accepted at edge N is on the outputs with `out_valid`=1 after edge N; earliest downstream consume is edge N+1.
- Throughput: 1 entry/cycle while `out_ready`=1, in both configurations.
- Simultaneous accept and transfer out on the same edge: the new entry replaces the departing one, and `out_valid` stays 1.
- `out_valid` and all `out_*` come directly from registers, apart from the masking muxes.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: a two-entry stage (main + skid register).
  - `in_ready` = !skid_valid, registered, with no combinational path from `out_ready`.
  - When the main register is stalled and a beat is accepted, that beat goes to skid. `in_ready` drops on the next cycle.
  - On the next transfer out, skid moves to main and `in_ready` returns to 1.
  - Capacity is 2 entries.
- Not defined: a single register.
  - `in_ready = !flush && (!out_valid || out_ready)`, combinational.
  - Capacity is 1 entry.
- The port list is identical in both builds.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `in_valid`=1 -> `out_valid`=0, `out_inst`=0x00000013, `out_ctrl`=0, `out_data`=0, `stall_cnt`=0.
- Streaming: `out_ready`=1, push data 1..8 with `in_ctrl`=1 on consecutive cycles -> the outputs carry 1..8 one cycle later, one per cycle, with no gaps.
- Back-pressure: push 0xA, 0xB, 0xC with `out_ready`=0 for 4 cycles, then release.
  - With skid: 0xA and 0xB are held, `in_ready`=0 from the third cycle, and 0xC is not accepted until release.
  - Without skid: only 0xA is held.
  - In both: `stall_cnt`=4, and order is preserved after release.
- Flush: with 2 entries held and `in_valid`=1 on 0xD, pulse `flush` for 1 cycle -> next cycle `out_valid`=0, `out_ctrl`=0, `out_inst`=NOP; 0xD is never emitted.
- Saturation: `CNT_W`=4, stall 20 cycles -> `stall_cnt`=15 and holds.
- Mid-stall reset: skid full, `reset`=0 for one edge -> both entries are lost, `in_ready`=1, and `stall_cnt`=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Handshaked pipeline stage register carrying a payload, a 32-bit
//   instruction word and a control bundle. Supports flush, bubble masking
//   (an empty stage presents NOP_INST and all-zero control) and a saturating
//   back-pressure counter.
//
//   Build option: define PIPE_STAGE_SKID_EN for a two-entry stage
//   (main + skid register) whose in_ready depends only on registered state.
//   Without it, the stage is a single register with a combinational in_ready.
//
// Parameters:
//   DATA_W   payload width
//   CTRL_W   control bundle width
//   CNT_W    stall counter width
//   NOP_INST instruction word presented while the stage holds a bubble
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-low reset
//   flush      kills held and incoming entries at the edge
//   in_valid   upstream entry present
//   in_ready   stage accepts an entry this cycle
//   in_data    upstream payload
//   in_inst    upstream instruction word
//   in_ctrl    upstream control bundle
//   out_valid  stage holds a valid entry
//   out_ready  downstream consumes the entry this cycle
//   out_data   held payload (not masked)
//   out_inst   held instruction, or NOP_INST when empty
//   out_ctrl   held control, or zero when empty
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CTRL_W   = 1,
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_inst,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_inst,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       inst_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  stall_q;
  logic              accept;

  // in_ready already folds in !flush, so a flushed beat is never accepted.
  assign accept = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [31:0]       skid_inst_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  // Depends only on the skid register (and flush), never on out_ready.
  assign in_ready = !flush && !skid_valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      data_q       <= '0;
      inst_q       <= '0;
      ctrl_q       <= '0;
      skid_data_q  <= '0;
      skid_inst_q  <= '0;
      skid_ctrl_q  <= '0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (main_valid_q && !out_ready) begin
      // Main is stalled: a beat accepted now can only land in skid.
      if (accept) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= in_data;
        skid_inst_q  <= in_inst;
        skid_ctrl_q  <= in_ctrl;
      end
    end else if (skid_valid_q) begin
      // Main drains this edge; skid is older than any new beat
      // (in_ready was low), so it moves up first.
      main_valid_q <= 1'b1;
      data_q       <= skid_data_q;
      inst_q       <= skid_inst_q;
      ctrl_q       <= skid_ctrl_q;
      skid_valid_q <= 1'b0;
    end else if (accept) begin
      main_valid_q <= 1'b1;
      data_q       <= in_data;
      inst_q       <= in_inst;
      ctrl_q       <= in_ctrl;
    end else begin
      main_valid_q <= 1'b0;
    end
  end
`else
  assign in_ready = !flush && (!main_valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      data_q       <= '0;
      inst_q       <= '0;
      ctrl_q       <= '0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
    end else if (accept) begin
      main_valid_q <= 1'b1;
      data_q       <= in_data;
      inst_q       <= in_inst;
      ctrl_q       <= in_ctrl;
    end else if (out_ready) begin
      main_valid_q <= 1'b0;
    end
  end
`endif

  // Counts stalled edges regardless of flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (main_valid_q && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = data_q;
  assign out_inst  = main_valid_q ? inst_q : NOP_INST;
  assign out_ctrl  = main_valid_q ? ctrl_q : '0;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. A source queue feeds the input
// handshake; accepted beats are pushed onto a scoreboard queue and the head
// of that queue is compared with the stage outputs every cycle. The bench
// follows whichever build (PIPE_STAGE_SKID_EN or not) it is compiled with.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned CW  = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] i;
    logic        c;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic [31:0]   in_inst = '0;
  logic [0:0]    in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [31:0]   out_inst;
  logic [0:0]    out_ctrl;
  logic [CW-1:0] stall_cnt;

  pipe_stage_reg #(
    .DATA_W(32),
    .CTRL_W(1),
    .CNT_W(CW),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_inst(in_inst),
    .in_ctrl(in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_inst(out_inst),
    .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  ent_t          src[$];
  ent_t          sb[$];
  logic [31:0]   m_last = '0;
  logic [CW-1:0] m_stall = '0;
  bit            src_en = 1'b1;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] d, input logic c);
    ent_t e;
    e.d = d;
    e.i = 32'h0100_0000 | d;
    e.c = c;
    return e;
  endfunction

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic tick();
    logic exp_rdy;
    logic acc;
    ent_t h;
    h = (src.size() > 0) ? src[0] : '0;
    in_valid = src_en && (src.size() > 0);
    in_data  = h.d;
    in_inst  = h.i;
    in_ctrl  = h.c;
    #1;
    if (CAP == 2) exp_rdy = !flush && (sb.size() < 2);
    else          exp_rdy = !flush && ((sb.size() == 0) || out_ready);
    chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() > 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("stall_cnt", {28'b0, stall_cnt}, {28'b0, m_stall});
    chk("out_data", out_data, (sb.size() > 0) ? sb[0].d : m_last);
    chk("out_inst", out_inst, (sb.size() > 0) ? sb[0].i : NOP);
    chk("out_ctrl", {31'b0, out_ctrl}, {31'b0, (sb.size() > 0) ? sb[0].c : 1'b0});
    acc = reset && in_valid && exp_rdy;
    @(posedge clk);
    if (!reset) begin
      sb.delete();
      m_stall = '0;
      m_last  = '0;
    end else begin
      if ((sb.size() > 0) && !out_ready && (m_stall != '1)) m_stall++;
      if (flush) begin
        sb.delete();
      end else begin
        if ((sb.size() > 0) && out_ready) void'(sb.pop_front());
        if (acc) sb.push_back(h);
      end
      if (sb.size() > 0) m_last = sb[0].d;
    end
    if (acc) void'(src.pop_front());
    #1;
  endtask

  initial begin
    // Reset held two cycles with a beat offered.
    reset = 1'b0;
    src.push_back(mk(32'h55, 1'b1));
    tick(); tick();
    src.delete();
    reset = 1'b1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'h0000_0013);
    chk("rst_ctrl", {31'b0, out_ctrl}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_stall", {28'b0, stall_cnt}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    // Streaming 1..8 with a free-running consumer.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) src.push_back(mk(32'(i), 1'b1));
    for (int i = 0; i < 11; i++) tick();
    chk("stream_src_empty", 32'(src.size()), 32'd0);
    chk("stream_last", out_data, 32'd8);

    // Back-pressure: counter starts from zero.
    reset = 1'b0; tick(); reset = 1'b1;
    out_ready = 1'b0;
    src.push_back(mk(32'hA, 1'b1));
    src.push_back(mk(32'hB, 1'b0));
    src.push_back(mk(32'hC, 1'b1));
    for (int i = 0; i < 5; i++) tick();
    chk("bp_stall", {28'b0, stall_cnt}, 32'd4);
    chk("bp_held", 32'(sb.size()), 32'(CAP));
    chk("bp_head", out_data, 32'hA);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // Flush with entries held and 0xD offered.
    out_ready = 1'b0;
    src.push_back(mk(32'hE0, 1'b1));
    src.push_back(mk(32'hE1, 1'b1));
    for (int i = 0; i < 3; i++) tick();
    src.delete();
    src.push_back(mk(32'hD, 1'b1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    src.delete();
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_ctrl", {31'b0, out_ctrl}, 32'd0);
    chk("fl_inst", out_inst, NOP);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("fl_no_d", out_data, 32'hE0);

    // Saturation of a 4-bit counter.
    reset = 1'b0; tick(); reset = 1'b1;
    out_ready = 1'b0;
    src.push_back(mk(32'h77, 1'b1));
    for (int i = 0; i < 21; i++) tick();
    chk("sat_stall", {28'b0, stall_cnt}, 32'd15);
    tick();
    chk("sat_hold", {28'b0, stall_cnt}, 32'd15);

    // Reset while stalled and full.
    src.push_back(mk(32'h88, 1'b0));
    src.push_back(mk(32'h99, 1'b1));
    tick(); tick();
    reset = 1'b0;
    src_en = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_ready", {31'b0, in_ready}, 32'd1);
    chk("mrst_stall", {28'b0, stall_cnt}, 32'd0);
    out_ready = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
